// File: rtl/pipe_id_ex_stage.sv
// ID/EX pipeline stage with valid/ready handshake, 2-entry skid buffer and flush.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipe_id_ex_stage #(
    parameter int DATA_W = 26,
    parameter int PC_W   = 16,
    parameter int NREGS  = 13,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [DATA_W-1:0]       in_rd1,
    input  logic [DATA_W-1:0]       in_rd2,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [NREGS*DATA_W-1:0] in_bank,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [DATA_W-1:0]       out_rd1,
    output logic [DATA_W-1:0]       out_rd2,
    output logic [DATA_W-1:0]       out_imm,
    output logic [NREGS*DATA_W-1:0] out_bank,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]         pc;
        logic [DATA_W-1:0]       rd1;
        logic [DATA_W-1:0]       rd2;
        logic [DATA_W-1:0]       imm;
        logic [NREGS*DATA_W-1:0] bank;
    } pl_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t state;
    pl_t    main_q;
    pl_t    skid_q;
    pl_t    in_pl;
    logic   ready_q;
    logic   valid_q;
    logic   accept;
    logic   emit;

    assign in_pl  = {in_pc, in_rd1, in_rd2, in_imm, in_bank};
    assign accept = in_valid & ready_q;
    assign emit   = valid_q & out_ready;

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_pc    = main_q.pc;
    assign out_rd1   = main_q.rd1;
    assign out_rd2   = main_q.rd2;
    assign out_imm   = main_q.imm;
    assign out_bank  = main_q.bank;

    // ready/valid are registered alongside the state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= ONE;
                        main_q  <= in_pl;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_q <= in_pl;
                    end else if (accept) begin
                        state   <= FULL;
                        skid_q  <= in_pl;
                        ready_q <= 1'b0;
                    end else if (emit) begin
                        state   <= EMPTY;
                        main_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state   <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (valid_q && !out_ready && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush && state != EMPTY && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_id_ex_stage.sv
// Directed bench for pipe_id_ex_stage with a FIFO scoreboard checked every cycle.
// Counter checks depend on whether PIPE_STATS_EN is defined.
module tb_pipe_id_ex_stage;

    localparam int DATA_W = 26;
    localparam int PC_W   = 16;
    localparam int NREGS  = 13;
    localparam int CNT_W  = 4;
    localparam int BW     = NREGS * DATA_W;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [BW-1:0]     bank;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_rd1;
    logic [DATA_W-1:0] in_rd2;
    logic [DATA_W-1:0] in_imm;
    logic [BW-1:0]     in_bank;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [DATA_W-1:0] out_imm;
    logic [BW-1:0]     out_bank;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    bit   en       = 1'b0;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe_id_ex_stage #(
        .DATA_W(DATA_W),
        .PC_W  (PC_W),
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_rd1   (in_rd1),
        .in_rd2   (in_rd2),
        .in_imm   (in_imm),
        .in_bank  (in_bank),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_rd1  (out_rd1),
        .out_rd2  (out_rd2),
        .out_imm  (out_imm),
        .out_bank (out_bank),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_rd1   = DATA_W'(pc) * 26'd7 + 26'd1;
        in_rd2   = ~DATA_W'(pc);
        in_imm   = DATA_W'(pc) << 4;
        in_bank  = {NREGS{DATA_W'(pc) ^ 26'h1555555}};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: queue depth models occupancy; sampled mid-cycle.
    always @(negedge clk) begin
        if (en) begin
            int held;
            ent_t e;
            held = q.size();
            chk("out_valid", out_valid, held > 0);
            chk("in_ready", in_ready, held < 2);
            if (!out_valid) begin
                chk("bubble_pc", out_pc, 0);
                chk("bubble_bank", out_bank, 0);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", held != 0, 1);
                if (held != 0) begin
                    e = q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_rd1", out_rd1, e.rd1);
                    chk("sb_rd2", out_rd2, e.rd2);
                    chk("sb_imm", out_imm, e.imm);
                    chk("sb_bank", out_bank, e.bank);
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                e.pc   = in_pc;
                e.rd1  = in_rd1;
                e.rd2  = in_rd2;
                e.imm  = in_imm;
                e.bank = in_bank;
                q.push_back(e);
            end
        end
    end

    initial begin
        logic [BW-1:0] bk;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        send(16'h0055);

        // Reset with in_valid high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_bank", out_bank, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        en       = 1'b1;
        tick();

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(16'h0010 + 16'(i));
            tick();
            chk("stream_pc", out_pc, 16'h0010 + 16'(i));
            chk("stream_valid", out_valid, 1);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", out_valid, 0);

        // Back-pressure
        out_ready = 1'b0;
        send(16'h0020);
        tick();
        send(16'h0021);
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_pc", out_pc, 16'h0020);
        repeat (3) begin
            tick();
            chk("bp_stable", out_pc, 16'h0020);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_second", out_pc, 16'h0021);
        tick();
        chk("bp_empty", out_valid, 0);
`ifdef PIPE_STATS_EN
        chk("bp_stall_cnt", stall_cnt, 4);
`else
        chk("bp_stall_cnt", stall_cnt, 0);
`endif

        // Flush while FULL with a same-cycle input
        out_ready = 1'b0;
        send(16'h002A);
        tick();
        send(16'h002B);
        tick();
        send(16'h0030);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_pc", out_pc, 0);
        chk("fl_rd1", out_rd1, 0);
        chk("fl_imm", out_imm, 0);
        chk("fl_bank", out_bank, 0);
`ifdef PIPE_STATS_EN
        chk("fl_flush_cnt", flush_cnt, 1);
`else
        chk("fl_flush_cnt", flush_cnt, 0);
`endif
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_no_ghost", out_valid, 0);

        // Bank mapping
        bk = '0;
        bk[12*DATA_W +: DATA_W] = 26'h3FFFFFF;
        send(16'h0040);
        in_bank = bk;
        in_imm  = 26'h2000000;
        tick();
        in_valid = 1'b0;
        chk("bank_e12", out_bank[12*DATA_W +: DATA_W], 26'h3FFFFFF);
        chk("bank_all", out_bank, bk);
        chk("bank_imm", out_imm, 26'h2000000);
        tick();

        // Saturation
        out_ready = 1'b0;
        send(16'h0050);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_pc", out_pc, 16'h0050);
`ifdef PIPE_STATS_EN
        chk("sat_stall_cnt", stall_cnt, 15);
`else
        chk("sat_stall_cnt", stall_cnt, 0);
`endif
        out_ready = 1'b1;
        repeat (2) tick();
        chk("sb_drained", q.size(), 0);
        chk("final_empty", out_valid, 0);

        en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_id_ex_stage.md
Name: pipe_id_ex_stage

Overview:
- Parametrised ID/EX pipeline stage; it replaces the fixed-width, always-load ID/EX register.
- Carries PC, RD1, RD2, sign-extended immediate and a flattened register-bank snapshot from decode to execute.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with registered in_ready) and a synchronous flush for branch/hazard squash.

Parameters:
- DATA_W, 26, width of RD1/RD2/immediate and of each register-bank entry
- PC_W, 16, width of the program counter
- NREGS, 13, number of register-bank entries carried
- CNT_W, 16, width of the statistics counters (used only with PIPE_STATS_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- flush  in  1  squash all held entries
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  program counter
- in_rd1  in  DATA_W  register read data 1
- in_rd2  in  DATA_W  register read data 2
- in_imm  in  DATA_W  sign-extended immediate
- in_bank  in  NREGS*DATA_W  register bank; entry i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute accepts this cycle
- out_pc, out_rd1, out_rd2, out_imm, out_bank  out  same widths as the inputs  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STATS_EN only)
- flush_cnt  out  CNT_W  flush cycles that squashed at least one valid entry (PIPE_STATS_EN only)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state EMPTY, out_valid=0, in_ready=1, all payload outputs 0, both counters 0.
- accept = in_valid & in_ready; emit = out_valid & out_ready.
- States:
  - EMPTY: no entry held.
  - ONE: main register holds an entry.
  - FULL: main and skid registers both hold entries.
- out_valid = (state != EMPTY). in_ready = (state != FULL) and is driven from a flop, never combinationally from out_ready.
- Transitions:
  - EMPTY: accept -> ONE, main <= in.
  - ONE: accept & emit -> ONE, main <= in. accept & !emit -> FULL, skid <= in. !accept & emit -> EMPTY. Otherwise hold.
  - FULL: emit -> ONE, main <= skid. Otherwise hold.
- Latency: 1 cycle from accept in EMPTY, or from accept with emit in ONE, to out_valid. Throughput is 1 entry/cycle when out_ready stays high.
- Ordering is strict FIFO; no entry is lost or duplicated.
- Payload is stable while out_valid=1 and out_ready=0.
- Whenever the next state is EMPTY, the main payload is zeroed (the bubble is all-zero).
- Flush (synchronous):
  - Next state is EMPTY, both payloads zeroed, in_ready=1 next cycle.
  - Flush takes priority over any same-cycle accept or emit; the incoming entry is dropped.
  - An emit in the flush cycle still counts as consumed by execute.
- Priority: rst > flush > handshake.
- A reset asserted mid-transfer discards all entries; there is no partial update.
- in_valid while in_ready=0 is ignored; decode must hold its data.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each flush cycle where state != EMPTY.
  - Both counters saturate at 2^CNT_W-1 and clear only on rst.
- Undefined: stall_cnt and flush_cnt are tied to 0 and the counter logic is absent.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_pc=0, out_bank=0.
- Streaming: out_ready=1, send pc 0x0010, 0x0011, 0x0012 on consecutive cycles -> out_valid high on cycles 1-3 carrying 0x0010/0x0011/0x0012 in order, in_ready stays 1.
- Back-pressure:
  - Hold out_ready=0 and send pc 0x0020 and 0x0021 -> in_ready=0 after the second accept, out_pc=0x0020 stable.
  - Release out_ready -> 0x0020 then 0x0021 emitted; with PIPE_STATS_EN, stall_cnt equals the number of held cycles.
- Flush with FULL state plus in_valid=1 (pc 0x0030) in the same cycle -> next cycle out_valid=0, all payload 0, in_ready=1, 0x0030 never appears; flush_cnt=1.
- Bank mapping: in_bank entry 12 = 0x3FFFFFF, others 0, imm=0x2000000 -> out_bank bits [12*26 +: 26]=0x3FFFFFF and out_imm=0x2000000 after 1 cycle.
- Saturation (CNT_W=4, PIPE_STATS_EN): stall for 20 cycles -> stall_cnt=15, no wrap.
